flag_reg_arbiter: RTL and testbench
===================================

// Module: flag_reg_arbiter
// PURPOSE
//   Shares one 4-bit register (condition flags) among NUM_REQ writers.
//   Each writer issues a req/wdata pair. The block selects one writer per cycle with a
//   round-robin scheme, issues a registered grant and writes that writer's data into the
//   internal register. An optional lock lets a writer keep the grant for a short burst.
//   Sits between the ALU/restore/debug write paths and the flag storage.
// PARAMETERS
//   NUM_REQ   4  number of requesters (2..8)
//   WIDTH     4  register width in bits
//   MAX_HOLD  4  max consecutive granted cycles for one locked requester (>=1)
// PORTS
//   clk      input   1                clock; all state changes on the rising edge
//   rst      input   1                asynchronous, active-low reset
//   req      input   NUM_REQ          per-requester write request
//   lock     input   NUM_REQ          per-requester burst hold request; ignored without req
//   wdata    input   NUM_REQ*WIDTH    write data; requester i uses slice [i*WIDTH +: WIDTH]
//   gnt      output  NUM_REQ          one-hot registered grant; a write happens in every gnt cycle
//   ack      output  NUM_REQ          one-cycle pulse, one cycle after each gnt cycle (write committed)
//   reg_out  output  WIDTH            current register contents
//   busy     output  1                |gnt
// BEHAVIOUR
//   Reset (rst=0, async): gnt=0, ack=0, reg_out=0, busy=0, rr_ptr=0, hold_cnt=0, state=IDLE.
//     Reset asserted mid-write aborts the write; reg_out reads 0 and no ack is issued.
//   States:
//     IDLE: no grant.
//     GRANT: gnt one-hot on winner w; writes wdata[w] into the register.
//   Arbitration, every edge where the block is not holding:
//     eligible = req; winner = first set bit scanning from rr_ptr upward, with wrap.
//     If any bit is eligible -> GRANT(winner) next cycle, hold_cnt=0. Otherwise -> IDLE.
//   Write path: in a cycle with gnt[w]=1, reg_out takes wdata[w] at the closing edge.
//     Latency is req sampled at edge E -> gnt high cycle E+1 -> reg_out/ack updated cycle E+2.
//   rr_ptr update: on release of w, rr_ptr = (w+1) mod NUM_REQ. It does not change while holding.
//   Hold: at the closing edge of a GRANT cycle, stay on w (gnt unchanged, another write) when all hold:
//     req[w]=1, lock[w]=1 and hold_cnt < MAX_HOLD-1.
//     In that case hold_cnt is incremented. Otherwise release and arbitrate.
//     The released w is lowest priority. If w is the only requester it is regranted immediately.
//   Requester rule: drop req, or change wdata, in the cycle gnt[i] is seen.
//     req[i] still high at the closing edge of its gnt cycle is a new request, unless a hold applies.
//   Back-to-back grants to different requesters need no idle cycle.
//     Full throughput is one write per cycle.
//   ack[i] is registered from gnt[i]. A burst of k held cycles produces k consecutive ack pulses.
//   lock without req has no effect. A req dropped during a hold ends the hold at that edge.
//   MAX_HOLD=1 disables holding.
// STRUCTURE
//   Shared package: state encoding localparams (ST_IDLE, ST_GRANT) and the
//     WIDTH/NUM_REQ defaults used by the flag path.
//   Sub-module rr_pick: combinational round-robin picker.
//     Inputs: eligible[NUM_REQ], ptr. Outputs: onehot[NUM_REQ], any.
//   Top level holds the grant/pointer/hold registers, the wdata mux and the WIDTH-bit storage.
//     The storage is a plain async-reset register with write enable = busy.
// TESTING
//   1 Reset release, no req for 5 cycles -> gnt=0, ack=0, reg_out=4'h0 throughout.
//   2 req=4'b0001 with wdata0=4'hA for 1 cycle ->
//     gnt=0001 next cycle, then ack=0001 and reg_out=4'hA.
//   3 req=4'b1111 held, lock=0, distinct data 4'h1..4'h4 ->
//     grants cycle 0001,0010,0100,1000,0001; reg_out follows 1,2,3,4.
//   4 req1 and lock1 held, req2 held, MAX_HOLD=4 ->
//     gnt=0010 for exactly 4 cycles, then gnt=0100, then back to 0010.
//   5 rst pulsed low mid-GRANT with wdata=4'hF ->
//     gnt/ack drop immediately, reg_out=0, rr_ptr=0; after release req3 granted first.
//   6 Only req2 held continuously, no lock -> gnt=0100 every cycle, ack=0100 every cycle after the first.

Source files
------------

// File: rtl/flag_reg_arbiter_pkg.sv
// Shared types and defaults for the condition-flag write arbiter.
package flag_reg_arbiter_pkg;
    localparam int FLAG_WIDTH   = 4;
    localparam int FLAG_NUM_REQ = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;
endpackage

// File: rtl/flag_reg_arbiter_if.sv
// Requester-side bundle: write requests in, grant/ack/register contents out.
interface flag_reg_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            lock;
    logic [NUM_REQ-1:0][WIDTH-1:0] wdata;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            ack;
    logic [WIDTH-1:0]              reg_out;
    logic                          busy;

    modport master (output req, lock, wdata, input gnt, ack, reg_out, busy);
    modport slave  (input req, lock, wdata, output gnt, ack, reg_out, busy);
endinterface

// File: rtl/flag_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible bit at or above ptr, with wrap.
module flag_reg_arbiter_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PW      = 2
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic               any
);
    logic [PW:0]   sum;
    logic [PW-1:0] sel;

    always_comb begin
        onehot = '0;
        any    = 1'b0;
        sum    = '0;
        sel    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(NUM_REQ))
                sum = sum - (PW+1)'(NUM_REQ);
            sel = sum[PW-1:0];
            if (!any && eligible[sel]) begin
                onehot[sel] = 1'b1;
                any         = 1'b1;
            end
        end
    end
endmodule

// File: rtl/flag_reg_arbiter.sv
// Round-robin arbiter sharing one flag register among NUM_REQ writers,
// with a bounded lock-hold so one writer can keep the grant for a burst.
module flag_reg_arbiter
    import flag_reg_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = FLAG_NUM_REQ,
    parameter int WIDTH    = FLAG_WIDTH,
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst,
    flag_reg_arbiter_if.slave  bus
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int HW = $clog2(MAX_HOLD) + 1;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] ack_q;
    logic [WIDTH-1:0]   reg_q;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [HW-1:0]      hold_q, hold_d;

    logic [PW-1:0]      win_idx;
    logic [PW-1:0]      release_ptr;
    logic [PW-1:0]      pick_ptr;
    logic [NUM_REQ-1:0] pick_oh;
    logic               pick_any;
    logic               hold_ok;
    logic               busy;

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (gnt_q[i]) win_idx = PW'(i);
    end

    // Arbitrating at the release edge already uses the advanced pointer,
    // so the releasing writer ranks last in the very same decision.
    assign release_ptr = (win_idx == PW'(NUM_REQ-1)) ? '0 : win_idx + PW'(1);
    assign pick_ptr    = (state_q == ST_GRANT) ? release_ptr : ptr_q;
    assign hold_ok     = (state_q == ST_GRANT) && bus.req[win_idx] && bus.lock[win_idx]
                         && (hold_q < HW'(MAX_HOLD-1));

    flag_reg_arbiter_rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_rr_pick (
        .eligible (bus.req),
        .ptr      (pick_ptr),
        .onehot   (pick_oh),
        .any      (pick_any)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        if (hold_ok) begin
            hold_d = hold_q + HW'(1);
        end else begin
            ptr_d  = pick_ptr;
            hold_d = '0;
            if (pick_any) begin
                state_d = ST_GRANT;
                gnt_d   = pick_oh;
            end else begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            ack_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ack_q   <= gnt_q;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign busy = |gnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            reg_q <= '0;
        else if (busy)
            reg_q <= bus.wdata[win_idx];
    end

    assign bus.gnt     = gnt_q;
    assign bus.ack     = ack_q;
    assign bus.reg_out = reg_q;
    assign bus.busy    = busy;
endmodule

// File: tb/tb_flag_reg_arbiter.sv
// Directed bench for flag_reg_arbiter: reset, single write, round robin, lock hold,
// mid-grant reset and a lone continuous requester.
module tb_flag_reg_arbiter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    flag_reg_arbiter_if #(.NUM_REQ(4), .WIDTH(4)) bus ();

    flag_reg_arbiter #(.NUM_REQ(4), .WIDTH(4), .MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic [3:0] a,
                           input logic [3:0] r);
        chk({tag, ".gnt"},  32'(bus.gnt),     32'(g));
        chk({tag, ".ack"},  32'(bus.ack),     32'(a));
        chk({tag, ".reg"},  32'(bus.reg_out), 32'(r));
        chk({tag, ".busy"}, 32'(bus.busy),    32'(|g));
    endtask

    initial begin
        bus.req   = '0;
        bus.lock  = '0;
        bus.wdata = '0;

        // reset state
        tick(); tick();
        chk_out("rst", 4'h0, 4'h0, 4'h0);
        #3 rst_n = 1'b1;

        // idle with no requests
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("idle", 4'h0, 4'h0, 4'h0);
        end

        // single write from requester 0
        bus.req   = 4'b0001;
        bus.wdata = 16'h000A;
        tick(); chk_out("single.g", 4'b0001, 4'h0, 4'h0);
        bus.req = 4'b0000;
        tick(); chk_out("single.a", 4'b0000, 4'b0001, 4'hA);
        tick(); chk_out("single.q", 4'b0000, 4'b0000, 4'hA);

        // reset to bring the pointer back to 0
        rst_n = 1'b0;
        #1 chk("rst2.reg", 32'(bus.reg_out), 32'h0);
        tick();
        #3 rst_n = 1'b1;

        // all four requesting, no lock: strict rotation
        bus.req   = 4'b1111;
        bus.wdata = 16'h4321;
        tick(); chk_out("rr0", 4'b0001, 4'b0000, 4'h0);
        tick(); chk_out("rr1", 4'b0010, 4'b0001, 4'h1);
        tick(); chk_out("rr2", 4'b0100, 4'b0010, 4'h2);
        tick(); chk_out("rr3", 4'b1000, 4'b0100, 4'h3);
        tick(); chk_out("rr4", 4'b0001, 4'b1000, 4'h4);
        bus.req = 4'b0000;
        tick(); chk_out("rr5", 4'b0000, 4'b0001, 4'h1);

        // requester 1 locked, requester 2 competing; pointer now 1
        bus.req   = 4'b0110;
        bus.lock  = 4'b0010;
        bus.wdata = 16'h0650;
        tick(); chk_out("hold0", 4'b0010, 4'b0000, 4'h1);
        tick(); chk_out("hold1", 4'b0010, 4'b0010, 4'h5);
        tick(); chk_out("hold2", 4'b0010, 4'b0010, 4'h5);
        tick(); chk_out("hold3", 4'b0010, 4'b0010, 4'h5);
        tick(); chk_out("hold4", 4'b0100, 4'b0010, 4'h5);
        tick(); chk_out("hold5", 4'b0010, 4'b0100, 4'h6);
        bus.req  = 4'b0000;
        bus.lock = 4'b0000;
        tick(); chk_out("hold6", 4'b0000, 4'b0010, 4'h5);

        // reset in the middle of a grant aborts the write
        bus.req   = 4'b0001;
        bus.wdata = 16'h000F;
        tick(); chk_out("mid.g", 4'b0001, 4'b0000, 4'h5);
        #2 rst_n = 1'b0;
        #1 chk_out("mid.rst", 4'h0, 4'h0, 4'h0);
        bus.req   = 4'b1000;
        bus.wdata = 16'h7000;
        tick(); chk_out("mid.hold", 4'h0, 4'h0, 4'h0);
        #3 rst_n = 1'b1;
        tick(); chk_out("mid.r3", 4'b1000, 4'b0000, 4'h0);
        bus.req = 4'b0000;
        tick(); chk_out("mid.a3", 4'b0000, 4'b1000, 4'h7);

        // lone continuous requester regranted every cycle
        bus.req   = 4'b0100;
        bus.wdata = 16'h0B00;
        tick(); chk_out("solo0", 4'b0100, 4'b0000, 4'h7);
        for (int i = 0; i < 3; i++) begin
            tick(); chk_out("solo", 4'b0100, 4'b0100, 4'hB);
        end
        bus.req = 4'b0000;
        tick(); chk_out("solo.e", 4'b0000, 4'b0100, 4'hB);
        tick(); chk_out("solo.z", 4'b0000, 4'b0000, 4'hB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
